serial_adder_ctrl: RTL and testbench

- Bit-serial N-bit adder controller, directly upstream and downstream of adder_1bit.
- Accepts two parallel operands over a valid/ready handshake.
- Feeds them LSB-first into one adder_1bit instance, holding the carry in a flip-flop between cycles.
- Collects the Sum bits into a result shift register and presents the N-bit result plus carry-out over a second valid/ready handshake.

---
 rtl/serial_adder_ctrl_if.sv | 56 +++++
 rtl/serial_adder_ctrl.sv | 154 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for the bit-serial adder controller.
// Carries the operand-side and result-side valid/ready channels.
//
// Signals:
//   in_valid/in_ready   operand handshake (a, b, cin[, sub])
//   out_valid/out_ready result handshake (sum, cout)
//   busy                controller is in SHIFT or DONE
// Optional: SERIAL_ADDER_SUB_EN adds the 1-bit sub request.
interface serial_adder_ctrl_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         busy;

`ifdef SERIAL_ADDER_SUB_EN
  modport slave (
    input  in_valid, a, b, cin, sub,
    input  out_ready,
    output in_ready, out_valid,
    output sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin, sub,
    output out_ready,
    input  in_ready, out_valid,
    input  sum, cout, busy
  );
`else
  modport slave (
    input  in_valid, a, b, cin,
    input  out_ready,
    output in_ready, out_valid,
    output sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin,
    output out_ready,
    input  in_ready, out_valid,
    input  sum, cout, busy
  );
`endif

endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: operands shift LSB-first through one
// full-adder cell, carry held in a flop, sum collected MSB-in.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_ctrl_if.slave (operand/result handshakes)
// Macro SERIAL_ADDER_SUB_EN: adds sub input; a-b via ~b and carry=1.

module adder_1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic p;

  assign p    = A ^ B;
  assign Sum  = p ^ Cin;
  assign Cout = (A & B) | (Cin & p);

endmodule

module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_sr_q, a_sr_d;
  logic [N-1:0]  b_sr_q, b_sr_d;
  logic [N-1:0]  sum_sr_q, sum_sr_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          fa_b;
  logic          fa_sum;
  logic          fa_cout;
  logic          accept;
  logic          carry_init;

`ifdef SERIAL_ADDER_SUB_EN
  logic          sub_q, sub_d;

  // Subtract is a + ~b + 1: invert B per bit, seed carry with 1.
  assign fa_b       = b_sr_q[0] ^ sub_q;
  assign carry_init = bus.sub ? 1'b1 : bus.cin;
`else
  assign fa_b       = b_sr_q[0];
  assign carry_init = bus.cin;
`endif

  adder_1bit u_fa (
    .A    (a_sr_q[0]),
    .B    (fa_b),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  assign accept = bus.in_valid & (state_q == S_IDLE);

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d    = sub_q;
`endif
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (accept) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          sum_sr_d = '0;
          carry_d  = carry_init;
          cnt_d    = '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d    = bus.sub;
`endif
          state_d  = S_SHIFT;
        end
      end
      (state_q == S_SHIFT): begin
        sum_sr_d = {fa_sum, sum_sr_q[N-1:1]};
        a_sr_d   = {1'b0, a_sr_q[N-1:1]};
        b_sr_d   = {1'b0, b_sr_q[N-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end
      end
      (state_q == S_DONE): begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end
`endif

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.sum       = sum_sr_q;
  assign bus.cout      = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (N=8).
// Expected results are queued at accept and popped at out_valid.
module tb_serial_adder_ctrl;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [N:0] sb_q[$];

  serial_adder_ctrl_if #(.N(N)) bus ();

  serial_adder_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [N:0] model(
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic         ci,
    input logic         sb
  );
    logic [N-1:0] nb;
    nb = ~b;
    if (sb) return {1'b0, a} + {1'b0, nb} + (N+1)'(1);
    return {1'b0, a} + {1'b0, b} + (N+1)'(ci);
  endfunction

  task automatic op_start(
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic         ci,
    input logic         sb
  );
    bus.a   = a;
    bus.b   = b;
    bus.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sb;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sb_q.push_back(model(a, b, ci, sb));
  endtask

  task automatic wait_out(output int cyc, output bit to);
    cyc = 0;
    to  = 1'b1;
    while (cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.out_valid) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_out;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", bus.busy);
    end
    checks++;
    if (bus.sum !== '0) begin
      errors++;
      $display("FAIL reset_sum got %h exp 00", bus.sum);
    end
    checks++;
    if (bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_cout got %b exp 0", bus.cout);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_basic;
    int         cyc;
    bit         to;
    logic [N:0] exp;
    op_start(8'h35, 8'h4A, 1'b0, 1'b0);
    wait_out(cyc, to);
    checks++;
    if (to || cyc != N) begin
      errors++;
      $display("FAIL basic_latency got %0d to=%0d exp %0d", cyc, to, N);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL basic_result got %h exp %h",
               {bus.cout, bus.sum}, exp);
    end
    release_out();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got rdy=%b vld=%b exp 1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_carry;
    int         cyc;
    bit         to;
    logic [N:0] exp;
    logic [N-1:0] av[2];
    logic [N-1:0] bv[2];
    logic         cv[2];
    av[0] = 8'hFF; bv[0] = 8'h01; cv[0] = 1'b0;
    av[1] = 8'h00; bv[1] = 8'h00; cv[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op_start(av[i], bv[i], cv[i], 1'b0);
      wait_out(cyc, to);
      exp = sb_q.pop_front();
      checks++;
      if (to || {bus.cout, bus.sum} !== exp) begin
        errors++;
        $display("FAIL carry_%0d got %h exp %h to=%0d",
                 i, {bus.cout, bus.sum}, exp, to);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure;
    int         cyc;
    bit         to;
    logic [N:0] exp;
    logic [N:0] held;
    op_start(8'hA5, 8'h3C, 1'b1, 1'b0);
    bus.a = 8'h11;
    bus.b = 8'h11;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    wait_out(cyc, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || {bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL bp_result got %h exp %h to=%0d",
               {bus.cout, bus.sum}, exp, to);
    end
    held = exp;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.cout, bus.sum} !== held) begin
        errors++;
        $display("FAIL bp_hold_%0d got vld=%b rdy=%b res=%h exp 1/0/%h",
                 i, bus.out_valid, bus.in_ready,
                 {bus.cout, bus.sum}, held);
      end
    end
    bus.in_valid = 1'b0;
    release_out();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got rdy=%b exp 1", bus.in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp_ignored got busy=%b q=%0d exp 0/0",
               bus.busy, sb_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int         cyc;
    bit         to;
    logic [N:0] exp;
    op_start(8'hFF, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sum !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got vld=%b busy=%b sum=%h rdy=%b exp 0/0/00/1",
               bus.out_valid, bus.busy, bus.sum, bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op_start(8'h80, 8'h80, 1'b0, 1'b0);
    wait_out(cyc, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || {bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL rst_after got %h exp %h to=%0d",
               {bus.cout, bus.sum}, exp, to);
    end
    release_out();
  endtask

  task automatic test_back_to_back;
    int         e;
    int         nacc;
    int         nres;
    int         acc[2];
    logic       rdy_pre;
    logic [N:0] exp;
    e = 0;
    nacc = 0;
    nres = 0;
    acc[0] = 0;
    acc[1] = 0;
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    rdy_pre = bus.in_ready;
    while (nres < 2 && e < 100) begin
      @(posedge clk);
      e++;
      #1;
      if (rdy_pre && bus.in_valid) begin
        sb_q.push_back(model(bus.a, bus.b, bus.cin, 1'b0));
        acc[nacc] = e;
        nacc++;
        if (nacc == 1) begin
          bus.a = 8'hF0;
          bus.b = 8'h0F;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        exp = sb_q.pop_front();
        checks++;
        if ({bus.cout, bus.sum} !== exp) begin
          errors++;
          $display("FAIL b2b_result_%0d got %h exp %h",
                   nres, {bus.cout, bus.sum}, exp);
        end
        nres++;
      end
      rdy_pre = bus.in_ready;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (nres != 2 || nacc != 2 || acc[1] - acc[0] != N + 2) begin
      errors++;
      $display("FAIL b2b_interval got %0d (acc=%0d res=%0d) exp %0d",
               acc[1] - acc[0], nacc, nres, N + 2);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int         cyc;
    bit         to;
    logic [N:0] exp;
    logic [N-1:0] av[4];
    logic [N-1:0] bv[4];
    logic         cv[4];
    av[0] = 8'h10; bv[0] = 8'h01; cv[0] = 1'b0;
    av[1] = 8'h00; bv[1] = 8'h01; cv[1] = 1'b0;
    av[2] = 8'h10; bv[2] = 8'h01; cv[2] = 1'b1;
    av[3] = 8'h00; bv[3] = 8'h01; cv[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_start(av[i], bv[i], cv[i], 1'b1);
      wait_out(cyc, to);
      exp = sb_q.pop_front();
      checks++;
      if (to || {bus.cout, bus.sum} !== exp) begin
        errors++;
        $display("FAIL sub_%0d got %h exp %h to=%0d",
                 i, {bus.cout, bus.sum}, exp, to);
      end
      release_out();
    end
    bus.sub = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_add_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
